crc8_checker: RTL

CRC8_CHECKER -- requirements
Module: crc8_checker

---
 rtl/crc8_pkg.sv | 25 ++
 rtl/crc8_lfsr_serial.sv | 29 ++
 rtl/crc8_checker.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions: default generator, CRC width, receiver FSM states and the
// single-bit LFSR step used by the serial checker (and any future serial transmitter).
package crc8_pkg;

  localparam int unsigned CrcW        = 8;
  // x^8 + x^7 + x^5 + x^4 + x^1 + x^0, x^8 term implicit.
  localparam logic [7:0]  DefaultPoly = 8'hB3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StCrc  = 2'd2,
    StDone = 2'd3
  } state_e;

  // One MSB-first step of a non-reflected CRC-8 LFSR.
  function automatic logic [7:0] next_crc(input logic [7:0] crc,
                                          input logic       bit_in,
                                          input logic [7:0] poly = DefaultPoly);
    logic [7:0] shifted;
    shifted = {crc[6:0], 1'b0};
    return (crc[7] ^ bit_in) ? (shifted ^ poly) : shifted;
  endfunction

endpackage

// File: rtl/crc8_lfsr_serial.sv
// Serial CRC-8 LFSR. clr restarts from zero; clr together with en restarts and absorbs
// bit_in in the same cycle, so a new frame's first bit is never lost.
module crc8_lfsr_serial
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY = DefaultPoly
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  // LFSR register: cleared on reset/clr, stepped once per enabled bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clr && en) begin
      crc <= next_crc(8'h00, bit_in, POLY);
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= next_crc(crc, bit_in, POLY);
    end
  end

endmodule

// File: rtl/crc8_checker.sv
// Serial CRC-8 frame checker. A frame is DATA_W data bits then 8 CRC bits, MSB first,
// qualified by bit_valid and started by sof. Results of each completed frame are
// registered in the one-cycle DONE state and held until the next completion.
// DATA_W must be at least 2.
module crc8_checker
  import crc8_pkg::*;
#(
  parameter logic [7:0]  POLY   = DefaultPoly,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sof,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              crc_ok,
  output logic [DATA_W-1:0] data_out,
  output logic [7:0]        crc_rx,
  output logic [7:0]        crc_calc,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned BcW     = $clog2((DATA_W > CrcW) ? DATA_W : CrcW);
  localparam logic [BcW-1:0] DataLast = BcW'(DATA_W - 1);
  localparam logic [BcW-1:0] CrcLast  = BcW'(CrcW - 1);

  state_e            state;
  logic [BcW-1:0]    bit_cnt;
  logic [DATA_W-1:0] data_sh;
  // Only the first seven CRC bits need storing; the eighth arrives with the capture.
  logic [6:0]        crc_sh;
  logic              lfsr_clr;
  logic              lfsr_en;
  logic [7:0]        lfsr_crc;
  logic [7:0]        rx_full;
  logic              rx_match;

  // LFSR control: any accepted sof restarts it with that bit; data bits step it.
  always_comb begin
    lfsr_clr = 1'b0;
    lfsr_en  = 1'b0;
    if (bit_valid) begin
      if (sof) begin
        lfsr_clr = 1'b1;
        lfsr_en  = 1'b1;
      end else if (state == StData) begin
        lfsr_en = 1'b1;
      end
    end
  end

  crc8_lfsr_serial #(
    .POLY (POLY)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (lfsr_clr),
    .en     (lfsr_en),
    .bit_in (bit_in),
    .crc    (lfsr_crc)
  );

  assign rx_full  = {crc_sh, bit_in};
  assign rx_match = (lfsr_crc == rx_full);
  assign busy     = (state == StData) || (state == StCrc);

  // Frame FSM, shift registers, result capture and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= StIdle;
      bit_cnt    <= '0;
      data_sh    <= '0;
      crc_sh     <= '0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      data_out   <= '0;
      crc_rx     <= 8'h00;
      crc_calc   <= 8'h00;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (bit_valid && sof) begin
        // Start (or abort and restart) a frame; this bit is data bit DATA_W-1.
        state   <= StData;
        bit_cnt <= BcW'(1);
        data_sh <= DATA_W'(bit_in);
        crc_sh  <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            state <= StIdle;
          end
          StData: begin
            if (bit_valid) begin
              data_sh <= (data_sh << 1) | DATA_W'(bit_in);
              if (bit_cnt == DataLast) begin
                state   <= StCrc;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + BcW'(1);
              end
            end
          end
          StCrc: begin
            if (bit_valid) begin
              crc_sh <= {crc_sh[5:0], bit_in};
              if (bit_cnt == CrcLast) begin
                state      <= StDone;
                bit_cnt    <= '0;
                frame_done <= 1'b1;
                data_out   <= data_sh;
                crc_rx     <= rx_full;
                crc_calc   <= lfsr_crc;
                crc_ok     <= rx_match;
                if (frame_cnt != '1) begin
                  frame_cnt <= frame_cnt + CNT_W'(1);
                end
                if (!rx_match && (err_cnt != '1)) begin
                  err_cnt <= err_cnt + CNT_W'(1);
                end
              end else begin
                bit_cnt <= bit_cnt + BcW'(1);
              end
            end
          end
          StDone: begin
            state <= StIdle;
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
